sram_dbus_ctrl: RTL and testbench

SRAM_DBUS_CTRL -- requirements
Module: sram_dbus_ctrl

---
 rtl/sram_dbus_ctrl.sv | 132 +++++++++++++
 tb/tb_sram_dbus_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dbus_ctrl.sv
// CPU data-bus to asynchronous 32-bit SRAM bridge.
// One access at a time; IDLE -> READ/WRITE -> DONE -> IDLE.
module sram_dbus_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int RAM_AW      = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       dbus_address,
  input  logic [3:0]        dbus_byteenable,
  input  logic              dbus_read,
  input  logic              dbus_write,
  input  logic [31:0]       dbus_wrdata,
  output logic [31:0]       dbus_rddata,
  output logic              dbus_stall,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_data_o,
  output logic              ram_data_oe,
  input  logic [31:0]       ram_data_i,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [3:0]        ram_be_n
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  localparam logic [3:0] LAST_RD = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] LAST_WR = 4'(WAIT_CYCLES);

  state_t            state;
  state_t            state_nx;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nx;
  logic              lat_ld;
  logic              dat_ld;
  logic              rd_ld;
  logic [RAM_AW-1:0] addr_q;
  logic [31:0]       data_q;
  logic [3:0]        be_q;
  logic              busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Write wins when both requests are raised together.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lat_ld   = 1'b0;
    dat_ld   = 1'b0;
    rd_ld    = 1'b0;
    unique case (state)
      IDLE: begin
        if (dbus_write) begin
          state_nx = WRITE;
          cnt_nx   = '0;
          lat_ld   = 1'b1;
          dat_ld   = 1'b1;
        end else if (dbus_read) begin
          state_nx = READ;
          cnt_nx   = '0;
          lat_ld   = 1'b1;
        end
      end
      READ: begin
        if (cnt == LAST_RD) begin
          state_nx = DONE;
          rd_ld    = 1'b1;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      WRITE: begin
        if (cnt == LAST_WR) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      data_q      <= '0;
      be_q        <= '0;
      dbus_rddata <= '0;
    end else begin
      if (lat_ld) begin
        addr_q <= dbus_address[RAM_AW+1:2];
        be_q   <= dbus_byteenable;
      end
      if (dat_ld) begin
        data_q <= dbus_wrdata;
      end
      if (rd_ld) begin
        dbus_rddata <= ram_data_i;
      end
    end
  end

  assign busy = (state == READ) || (state == WRITE);

  // Last WRITE cycle releases we_n while data is still driven (hold).
  assign ram_ce_n    = !busy;
  assign ram_oe_n    = !(state == READ);
  assign ram_we_n    = !((state == WRITE) && (cnt < LAST_WR));
  assign ram_data_oe = (state == WRITE);
  assign ram_be_n    = busy ? ~be_q : 4'hF;
  assign ram_addr    = addr_q;
  assign ram_data_o  = data_q;

  assign dbus_stall = ((dbus_read || dbus_write) && (state == IDLE))
                    || busy;

endmodule

// File: tb/tb_sram_dbus_ctrl.sv
// Directed bench for sram_dbus_ctrl with a small SRAM model.
// Inputs change on negedge; outputs sampled 1 ns later.
module tb_sram_dbus_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] dbus_address;
  logic [3:0]  dbus_byteenable;
  logic        dbus_read;
  logic        dbus_write;
  logic [31:0] dbus_wrdata;
  logic [31:0] dbus_rddata;
  logic        dbus_stall;
  logic [19:0] ram_addr;
  logic [31:0] ram_data_o;
  logic        ram_data_oe;
  logic [31:0] ram_data_i;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic [3:0]  ram_be_n;

  int checks;
  int failures;

  int n_stall;
  int n_wen;
  int n_oen;
  int n_oe;
  int n_clash;
  logic [3:0]  be_seen;
  logic [19:0] addr_seen;
  logic [7:0]  stall_pat;

  logic [31:0] mem [0:15];

  sram_dbus_ctrl #(
    .WAIT_CYCLES(2),
    .RAM_AW(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dbus_address(dbus_address),
    .dbus_byteenable(dbus_byteenable),
    .dbus_read(dbus_read),
    .dbus_write(dbus_write),
    .dbus_wrdata(dbus_wrdata),
    .dbus_rddata(dbus_rddata),
    .dbus_stall(dbus_stall),
    .ram_addr(ram_addr),
    .ram_data_o(ram_data_o),
    .ram_data_oe(ram_data_oe),
    .ram_data_i(ram_data_i),
    .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n),
    .ram_be_n(ram_be_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n) begin
      for (int i = 0; i < 4; i++) begin
        if (!ram_be_n[i]) mem[ram_addr[3:0]][8*i+:8] <= ram_data_o[8*i+:8];
      end
    end
  end

  assign ram_data_i = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[3:0]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (dbus_stall) n_stall++;
    if (!ram_we_n) n_wen++;
    if (!ram_oe_n) n_oen++;
    if (ram_data_oe) n_oe++;
    if (ram_data_oe && !ram_oe_n) n_clash++;
    if (!ram_ce_n) begin
      be_seen   = ram_be_n;
      addr_seen = ram_addr;
    end
  endtask

  // Request held from cycle 0, dropped in the last (DONE) cycle.
  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int n);
    n_stall = 0; n_wen = 0; n_oen = 0; n_oe = 0; n_clash = 0;
    be_seen = 4'hF; addr_seen = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        dbus_address    = a;
        dbus_wrdata     = d;
        dbus_byteenable = be;
        dbus_read       = rd;
        dbus_write      = wr;
      end
      if (k == n - 1) begin
        dbus_read  = 1'b0;
        dbus_write = 1'b0;
      end
      #1;
      sample();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    dbus_address = '0;
    dbus_byteenable = '0;
    dbus_read = 1'b0;
    dbus_write = 1'b0;
    dbus_wrdata = '0;

    #12;
    chk("rst_stall", dbus_stall, 0);
    chk("rst_ce_n", ram_ce_n, 1);
    chk("rst_oe_n", ram_oe_n, 1);
    chk("rst_we_n", ram_we_n, 1);
    chk("rst_be_n", ram_be_n, 4'hF);
    chk("rst_oe", ram_data_oe, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data_o", ram_data_o, 0);
    chk("rst_rddata", dbus_rddata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full word write, stepped cycle by cycle.
    @(negedge clk);
    dbus_address = 32'h8000_0010;
    dbus_wrdata = 32'hDEAD_BEEF;
    dbus_byteenable = 4'hF;
    dbus_write = 1'b1;
    #1;
    chk("wr_c0_stall", dbus_stall, 1);
    chk("wr_c0_ce_n", ram_ce_n, 1);
    @(negedge clk); #1;
    chk("wr_c1_ce_n", ram_ce_n, 0);
    chk("wr_c1_we_n", ram_we_n, 0);
    chk("wr_c1_oe_n", ram_oe_n, 1);
    chk("wr_c1_oe", ram_data_oe, 1);
    chk("wr_c1_addr", ram_addr, 20'h00004);
    chk("wr_c1_data", ram_data_o, 32'hDEAD_BEEF);
    chk("wr_c1_be_n", ram_be_n, 4'h0);
    @(negedge clk); #1;
    chk("wr_c2_we_n", ram_we_n, 0);
    @(negedge clk); #1;
    chk("wr_c3_we_n", ram_we_n, 1);
    chk("wr_c3_oe", ram_data_oe, 1);
    chk("wr_c3_stall", dbus_stall, 1);
    chk("wr_c3_data", ram_data_o, 32'hDEAD_BEEF);
    @(negedge clk);
    dbus_write = 1'b0;
    #1;
    chk("wr_done_stall", dbus_stall, 0);
    chk("wr_done_ce_n", ram_ce_n, 1);
    chk("wr_done_oe", ram_data_oe, 0);
    chk("wr_done_be_n", ram_be_n, 4'hF);
    chk("wr_rddata", dbus_rddata, 0);

    // Same-address write counted as a whole.
    access(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 5);
    chk("wr_n_stall", n_stall, 4);
    chk("wr_n_wen", n_wen, 2);
    chk("wr_n_oe", n_oe, 3);

    access(1, 0, 32'h8000_0010, 32'h0, 4'hF, 4);
    chk("rd_n_stall", n_stall, 3);
    chk("rd_n_oen", n_oen, 2);
    chk("rd_n_wen", n_wen, 0);
    chk("rd_clash", n_clash, 0);
    chk("rd_data", dbus_rddata, 32'hDEAD_BEEF);

    access(0, 1, 32'h0000_0010, 32'h00AB_0000, 4'b0100, 5);
    chk("bw_be_n", be_seen, 4'b1011);
    chk("bw_rddata", dbus_rddata, 32'hDEAD_BEEF);
    access(1, 0, 32'h0000_0010, 32'h0, 4'hF, 4);
    chk("bw_read", dbus_rddata, 32'hDEAB_BEEF);

    access(1, 1, 32'h0000_0010, 32'h1234_5678, 4'b0001, 5);
    chk("both_oen", n_oen, 0);
    chk("both_wen", n_wen, 2);
    chk("both_stall", n_stall, 4);
    chk("both_rddata", dbus_rddata, 32'hDEAB_BEEF);

    access(0, 1, 32'h0000_0020, 32'hCAFE_0000, 4'h0, 5);
    chk("be0_be_n", be_seen, 4'hF);
    chk("be0_wen", n_wen, 2);
    chk("be0_addr", addr_seen, 20'h00008);

    // Read held continuously: one access per 4 cycles.
    stall_pat = '0;
    n_oen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        dbus_address = 32'h0000_0010;
        dbus_read = 1'b1;
      end
      if (k == 7) dbus_read = 1'b0;
      #1;
      stall_pat[k] = dbus_stall;
      if (!ram_oe_n) n_oen++;
    end
    chk("b2b_stall_pat", stall_pat, 8'h77);
    chk("b2b_oen", n_oen, 4);
    chk("b2b_rddata", dbus_rddata, 32'hDEAB_BE78);

    // Reset during second WRITE cycle.
    @(negedge clk);
    dbus_address = 32'h0000_0020;
    dbus_wrdata = 32'h5555_AAAA;
    dbus_byteenable = 4'hF;
    dbus_write = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("ra_pre_we_n", ram_we_n, 0);
    rst_n = 1'b0;
    #1;
    chk("ra_ce_n", ram_ce_n, 1);
    chk("ra_we_n", ram_we_n, 1);
    chk("ra_oe", ram_data_oe, 0);
    chk("ra_be_n", ram_be_n, 4'hF);
    chk("ra_addr", ram_addr, 0);
    chk("ra_rddata", dbus_rddata, 0);
    dbus_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_stall = 0; n_wen = 0; n_oen = 0; n_oe = 0; n_clash = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      sample();
    end
    chk("ra_quiet_stall", n_stall, 0);
    chk("ra_quiet_strobes", n_wen + n_oen + n_oe, 0);
    chk("ra_quiet_ce_n", ram_ce_n, 1);

    access(1, 0, 32'h0000_0010, 32'h0, 4'hF, 4);
    chk("ra_rd_stall", n_stall, 3);
    chk("ra_rd_data", dbus_rddata, 32'hDEAB_BE78);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
